// File: rtl/prio_encoder8_3_irq.sv
// Purpose : sequential 8-to-3 priority encoder; latches falling edges on eight
//           active-low request lines and presents the highest pending index.
// Latency : a request falling before edge 1 is presented (valid=1) after edge
//           SYNC_STAGES+2; after each accept there is one valid=0 cycle.
// Backpressure: the presented code is held until ack; new edges keep being
//           captured into the pending set while a code waits.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   ei_low        active-low enable; 1 stops new codes from being presented
//   i_low[7:0]    asynchronous active-low requests, bit 7 highest priority
//   ack           consumer accepts the presented code
//   a[2:0]        index of the presented request
//   valid         a holds a pending request
//   gs_low        group select, ~valid
//   eo_low        0 only when enabled and nothing is pending or presented
//   pending[7:0]  current pending set
//   overrun       one-cycle pulse: a new edge hit an already-pending bit
//
// SYNC_STAGES is meant to be 2..4.
module prio_encoder8_3_irq #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ei_low,
  input  logic [7:0] i_low,
  input  logic       ack,
  output logic [2:0] a,
  output logic       valid,
  output logic       gs_low,
  output logic       eo_low,
  output logic [7:0] pending,
  output logic       overrun
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] prev;
  logic [7:0] s;
  logic [7:0] fall;
  logic [7:0] clr;
  logic [2:0] hi_idx;

  // Synchronizer chain and previous-sample register; idle level of the
  // lines is 1, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'hFF;
      prev <= 8'hFF;
    end else begin
      sync_q[0] <= i_low;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign fall = prev & ~s;

  // Only the presented bit is ever cleared, and only on the accepting edge.
  always_comb begin
    clr = '0;
    if (state == PRESENT && ack) clr[a] = 1'b1;
  end

  // Ascending scan: the last hit is the highest-numbered pending bit.
  always_comb begin
    hi_idx = '0;
    for (int k = 0; k < 8; k++) begin
      if (pending[k]) hi_idx = 3'(k);
    end
  end

  // Pending set: a fresh edge wins over a clear in the same cycle, so a
  // request re-arriving during its own ack is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | fall;
      overrun <= |(fall & pending & ~clr);
    end
  end

  // Presentation handshake. The code is frozen in PRESENT; ei_low only
  // gates starting a presentation, never withdraws one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!ei_low && (pending != 8'h00)) begin
            a     <= hi_idx;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign gs_low = ~valid;
  assign eo_low = ei_low | (pending != 8'h00) | valid;

endmodule

// File: doc/prio_encoder8_3_irq.md
Name: prio_encoder8_3_irq

Overview:
- Sequential 8-to-3 priority encoder; the encode-side counterpart of the team's 3-to-8 decoder.
- Latches falling edges on eight active-low request lines into a pending set.
- Presents the highest-numbered pending request as a 3-bit binary code with a valid/ack handshake.
- Clears each request only on acknowledge.
- Sits between raw request pins (keys, interrupt sources) and a consumer that typically drives the 3-to-8 decoder.

Parameters:
SYNC_STAGES, 2, synchronizer flops per request input (legal 2..4).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
ei_low  input  1  active-low enable; 1 blocks presenting new codes.
i_low  input  8  active-low asynchronous request lines; bit 7 is highest priority.
ack  input  1  consumer accepts the presented code.
a  output  3  binary index of the presented request.
valid  output  1  a holds a pending request.
gs_low  output  1  group select, always equal to ~valid.
eo_low  output  1  enable-out: 0 when ei_low=0 and no request is pending or presented.
pending  output  8  current pending set, for visibility.
overrun  output  1  one-cycle pulse: new edge on an already-pending bit.

Behaviour:
Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.

Reset (rst_n=0, immediate):
- All sync flops and prev-sample flops = 1.
- pending=0, a=0, valid=0, overrun=0, state=IDLE.
- Reset mid-handshake discards every pending request and the presented code. No ack is required afterwards.

Synchronizer and edge capture:
- Each i_low bit passes through SYNC_STAGES flops, giving s[k].
- fall[k] = prev[k] & ~s[k]. prev updates every cycle.
- A line held low sets its pending bit once only. A new request needs release to 1 and re-assertion.
- pending[k] next = (pending[k] & ~clr[k]) | fall[k]. Set wins over clear in the same cycle.
- overrun pulses high for exactly one cycle when fall[k] coincides with pending[k]=1 and clr[k]=0.
- Capture continues regardless of ei_low or state.

State machine (IDLE, PRESENT):
- IDLE, valid=0: if ei_low=0 and pending!=0, then at the next edge:
  - a <= index of the highest set pending bit;
  - valid <= 1;
  - go to PRESENT.
  Otherwise stay in IDLE.
- PRESENT, valid=1:
  - a is held stable and pending[a] stays set.
  - When ack=1 is sampled, then at that edge: clr[a]=1, valid <= 0, go to IDLE.
  - ei_low rising during PRESENT does not withdraw the code. The handshake completes normally.
- ack is ignored in IDLE. ack held high continuously yields one accept per presentation.
- After an accept there is always one valid=0 cycle. The next code (if any, and ei_low=0) appears on the following edge.
- A higher-priority request arriving during PRESENT does not preempt. It is presented after the current ack.

Latency and outputs:
- A request falling with setup met before edge 1 gives valid=1 after edge SYNC_STAGES+2 (edge 4 by default).
- eo_low = ei_low | (pending!=0) | valid. It is combinational from registers plus ei_low.
- gs_low = ~valid.

Test Plan:
- Reset, ei_low=0, i_low=8'hFF, no activity → a=0, valid=0, gs_low=1, eo_low=0, pending=0 indefinitely.
- i_low bit 5 falls once and is held low (SYNC_STAGES=2) → valid=1 after edge 4 with a=3'd5. Ack one cycle → valid=0 next edge, pending=0. Holding the bit low produces no second request.
- Bits 2, 6 and 7 fall in the same cycle; ack held high throughout → codes 7, 6, 2 presented in that order. Each is separated by one valid=0 cycle. Then pending=0 and eo_low=0.
- Bit 7 falls while code 1 is presented → a stays 1 until ack. Next presentation is a=7.
- Bit 3 pending and presented; bit 3 pulses high-low so that its fall lands in the ack cycle → pending[3] stays 1, overrun=0, and code 3 is re-presented. A second fall on bit 4 while bit 4 is pending → overrun is a single 1-cycle pulse.
- Pending bits present with ei_low=1 → valid stays 0 and eo_low=1. Dropping ei_low presents the highest pending bit. Asserting rst_n=0 mid-PRESENT → valid, a and pending clear immediately, with no clock needed.
